aliens_palram_arb: RTL
======================

ALIENS_PALRAM_ARB -- requirements
Module: aliens_palram_arb

Interface
REQ-001 SHALL have parameter AW, default 11: RAM address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive video grants allowed while a CPU request waits.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cpu_req  input  1  CPU access request (decoded palette chip-select), level, held until cpu_ack.
REQ-006 SHALL have port cpu_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-007 SHALL have port cpu_addr  input  AW  CPU address; sampled at grant.
REQ-008 SHALL have port cpu_din  input  8  CPU write data; sampled at grant.
REQ-009 SHALL have port cpu_dout  output  8  CPU read data; valid while cpu_ack=1.
REQ-010 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have port vid_req  input  1  one-cycle video fetch request pulse.
REQ-012 SHALL have port vid_addr  input  AW  video fetch address; sampled with vid_req.
REQ-013 SHALL have port vid_dout  output  8  video read data; valid while vid_valid=1.
REQ-014 SHALL have port vid_valid  output  1  one-cycle read-data-valid pulse.
REQ-015 SHALL have port vid_ovf  output  1  sticky overrun flag.
REQ-016 SHALL have port ram_addr  output  AW  RAM address.
REQ-017 SHALL have port ram_wdata  output  8  RAM write data.
REQ-018 SHALL have port ram_we  output  1  RAM write enable, one cycle per write.
REQ-019 SHALL have port ram_q  input  8  RAM read data, one-cycle latency after ram_addr.

Function
REQ-020 SHALL latch vid_req and vid_addr into a one-deep pending slot (vid_pend); slot cleared when its access is issued.
REQ-021 SHALL set vid_ovf when vid_req arrives while vid_pend=1 and the slot is not being issued that cycle; new request dropped, old one kept; vid_ovf cleared only by reset.
REQ-022 SHALL implement FSM states IDLE, VID_ISS, VID_DAT, CPU_ISS, CPU_DAT; each access occupies exactly two cycles (ISS, DAT).
REQ-023 SHALL arbitrate from IDLE or from any DAT state (back-to-back allowed): video wins if vid_pend=1 and starve_cnt<STARVE_MAX; else CPU wins if cpu_req eligible; else video if pending; else IDLE.
REQ-024 SHALL treat cpu_req as eligible only when high and not already serviced; after cpu_ack, cpu_req must be sampled low at least one cycle before a new CPU request is eligible.
REQ-025 SHALL increment starve_cnt (saturating at STARVE_MAX) on each video grant while an eligible CPU request waits; clear it on every CPU grant or when no CPU request is eligible.
REQ-026 In VID_ISS: ram_addr=latched vid_addr, ram_we=0. In VID_DAT: vid_dout=ram_q, vid_valid=1.
REQ-027 In CPU_ISS: ram_addr=latched cpu_addr; write: ram_wdata=latched cpu_din, ram_we=1. In CPU_DAT: cpu_ack=1; read: cpu_dout=ram_q.
REQ-028 SHALL hold ram_we=0 in every state other than CPU_ISS with write.
REQ-029 Latency: isolated request to valid/ack = 3 cycles after request sample (latch, ISS, DAT); CPU stall bounded by 2*STARVE_MAX+2 cycles.
REQ-030 SHALL hold cpu_dout and vid_dout at last value outside their valid pulses.
REQ-031 Simultaneous vid_req and cpu_req from IDLE with starve_cnt=0: video first, CPU granted next.

Reset
REQ-032 When reset_n=0 at a clock edge: state IDLE, vid_pend=0, starve_cnt=0, vid_ovf=0, cpu_ack=0, vid_valid=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_dout=0, vid_dout=0.
REQ-033 Reset mid-access SHALL abort it: no ack/valid issued, ram_we=0 from the first reset cycle; a cpu_req held through reset is serviced as a new request after release.

Verification
REQ-034 CPU write 0x5A to 0x123, no video -> ram_we=1 with ram_addr=0x123, ram_wdata=0x5A in one cycle; cpu_ack next cycle.
REQ-035 CPU read 0x123 after REQ-034 with ram model -> cpu_dout=0x5A with cpu_ack, 3 cycles after request.
REQ-036 vid_req pulses every 2 cycles + cpu_req held (STARVE_MAX=4) -> exactly 4 video accesses, then CPU access, cpu_ack within 10 cycles.
REQ-037 Two vid_req pulses while CPU access in progress -> second dropped, vid_ovf=1 and stays 1; first delivered with its address.
REQ-038 reset_n=0 during CPU_ISS write -> ram_we=0, no cpu_ack, all outputs reset values; after release with cpu_req high -> single write, single ack.
REQ-039 cpu_req held high after ack -> no second access until cpu_req low one cycle.

Source files
------------

// File: rtl/aliens_palram_arb.sv
// rtl/aliens_palram_arb.sv - palette RAM arbiter between CPU and video fetch
module aliens_palram_arb #(
  parameter int AW         = 11,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [7:0]    vid_dout,
  output logic          vid_valid,
  output logic          vid_ovf,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_q
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, VID_ISS, VID_DAT, CPU_ISS, CPU_DAT} state_t;

  state_t        state, state_n;
  logic          vid_pend;
  logic [AW-1:0] pend_addr;
  logic          cpu_q;
  logic          cpu_done;
  logic          acc_we;
  logic [CW-1:0] starve_cnt;
  logic [7:0]    cpu_dout_r;
  logic [7:0]    vid_dout_r;
  logic          cpu_elig;
  logic          arb_slot;
  logic          grant_vid;
  logic          grant_cpu;

  // cpu_req is registered so a CPU request and a same-cycle video pulse reach arbitration together
  always_comb begin
    cpu_elig  = cpu_q & ~cpu_done;
    arb_slot  = (state == IDLE) || (state == VID_DAT) || (state == CPU_DAT);
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (arb_slot) begin
      if (vid_pend && (starve_cnt < SMAX)) begin
        grant_vid = 1'b1;
      end else if (cpu_elig) begin
        grant_cpu = 1'b1;
      end else if (vid_pend) begin
        grant_vid = 1'b1;
      end
    end
    state_n = IDLE;
    case (state)
      VID_ISS: state_n = VID_DAT;
      CPU_ISS: state_n = CPU_DAT;
      default: begin
        if (grant_vid) begin
          state_n = VID_ISS;
        end else if (grant_cpu) begin
          state_n = CPU_ISS;
        end
      end
    endcase
  end

  assign cpu_ack   = (state == CPU_DAT);
  assign vid_valid = (state == VID_DAT);
  assign cpu_dout  = (cpu_ack && !acc_we) ? ram_q : cpu_dout_r;
  assign vid_dout  = vid_valid ? ram_q : vid_dout_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      vid_pend   <= 1'b0;
      pend_addr  <= '0;
      vid_ovf    <= 1'b0;
      cpu_q      <= 1'b0;
      cpu_done   <= 1'b0;
      acc_we     <= 1'b0;
      starve_cnt <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_dout_r <= '0;
      vid_dout_r <= '0;
    end else begin
      state      <= state_n;
      cpu_q      <= cpu_req;
      cpu_dout_r <= cpu_dout;
      vid_dout_r <= vid_dout;

      // a serviced request stays ineligible until cpu_req has been seen low
      if (grant_cpu) begin
        cpu_done <= 1'b1;
      end else if (!cpu_q) begin
        cpu_done <= 1'b0;
      end

      if (grant_cpu || !cpu_elig) begin
        starve_cnt <= '0;
      end else if (grant_vid && (starve_cnt < SMAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      // the slot frees up in the cycle it is issued, so a pulse then is accepted
      if (vid_req && (!vid_pend || grant_vid)) begin
        vid_pend  <= 1'b1;
        pend_addr <= vid_addr;
      end else if (grant_vid) begin
        vid_pend <= 1'b0;
      end
      if (vid_req && vid_pend && !grant_vid) begin
        vid_ovf <= 1'b1;
      end

      ram_we <= grant_cpu & cpu_we;
      if (grant_vid) begin
        ram_addr <= pend_addr;
      end else if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_din;
        acc_we    <= cpu_we;
      end
    end
  end

endmodule
